pengo_input_cond: RTL and testbench
===================================

PENGO_INPUT_COND -- requirements
Module: pengo_input_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd24000, consecutive stable cycles required before a debounced button changes state.
REQ-002 Parameter COIN_PULSE_CYCLES, default 20'd480000, length of the coin pulse in clk cycles.
REQ-003 Parameter DIM_TIMEOUT, default 32'hE4E1C00, paused cycles before dim_video asserts.
REQ-004 clk  in  1  system clock (24 MHz); single clock domain.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 joy  in  16  raw merged joystick, active-high: [0] right, [1] left, [2] down, [3] up, [4] fire, [5] start1/fire2, [6] start2, [7] coin, [8] pause.
REQ-007 hs_access  in  1  hiscore engine owns RAM; forces pause.
REQ-008 in0  out  8  active-low: ~{fire,0,coin,0,right,left,down,up}.
REQ-009 in1  out  8  active-low: ~{start1,start2,start1,0,right,left,down,up}.
REQ-010 pause  out  1  core pause, active-high.
REQ-011 dim_video  out  1  video dim request, active-high.

Function
REQ-012 Each of joy[8:0] SHALL pass through its own debouncer; joy[15:9] SHALL be ignored.
REQ-013 A debouncer SHALL flip its stable state on the DEBOUNCE_CYCLES-th consecutive cycle on which the raw input differs from that state; any matching sample SHALL clear its counter.
REQ-014 in0/in1 SHALL be registered from the debounced state: a raw change held steady appears DEBOUNCE_CYCLES+1 cycles later.
REQ-015 The coin FSM SHALL have three states: IDLE, PULSE, HOLD.
REQ-016 IDLE -> PULSE on a rising edge of debounced coin while pause_toggle=0; the coin bit of in0 SHALL be 0 for exactly COIN_PULSE_CYCLES cycles.
REQ-017 PULSE -> HOLD on terminal count; HOLD -> IDLE only once debounced coin is 0. A held coin therefore credits once.
REQ-018 Coin rising edges in PULSE or HOLD SHALL be ignored.
REQ-019 A rising edge of debounced pause SHALL toggle pause_toggle.
REQ-020 pause SHALL be registered as hs_access | pause_toggle, one cycle latency.
REQ-021 While pause_toggle=1, direction, fire and start bits SHALL read inactive (1) and coin edges SHALL be ignored. A PULSE already in progress SHALL complete.
REQ-022 If the pause edge and the coin edge arrive in the same cycle, the pause toggle SHALL take effect and the coin SHALL be decided on the pre-toggle pause_toggle value.
REQ-023 The pause timer (32 bit) SHALL increment each cycle while pause_toggle=1, saturate at DIM_TIMEOUT, and clear to 0 on the cycle pause_toggle becomes 0.
REQ-024 dim_video SHALL be registered as (timer >= DIM_TIMEOUT); hs_access alone SHALL never advance the timer.

Reset
REQ-025 Asserting reset_n low SHALL immediately set: in0=8'hFF, in1=8'hFF, pause=0, dim_video=0, pause_toggle=0, timer=0, coin FSM=IDLE, all debouncers stable=0 with counters=0.
REQ-026 Reset mid-pulse SHALL abort the coin pulse with no residual credit after release.
REQ-027 After release, the first cycle SHALL sample inputs normally. A button held through reset SHALL appear after the full debounce time.

Structure
REQ-028 Package pengo_input_pkg SHALL hold the joy bit-index constants (JOY_RIGHT..JOY_PAUSE), the coin FSM state enum, and the parameter defaults.
REQ-029 One sub-module, pengo_debounce (1-bit, parameterised count width), SHALL be instantiated nine times.
REQ-030 Counter widths SHALL be derived with $clog2 from their parameters; no counter may wrap.

Verification (DEBOUNCE_CYCLES=4, COIN_PULSE_CYCLES=8, DIM_TIMEOUT=16)
REQ-031 Drive joy[3]=1 steady -> in0[0] and in1[0] go 0 exactly 5 cycles later; a 3-cycle glitch on joy[0] -> no change on in0.
REQ-032 Hold joy[7]=1 for 40 cycles -> in0[5]=0 for exactly 8 cycles, then 1. Release and press again -> a second 8-cycle pulse.
REQ-033 Pulse joy[8] for 10 cycles -> pause=1 and in0=8'hFF with joy[3:0] held. After 16 paused cycles dim_video=1. A second joy[8] press -> pause=0, dim_video=0, timer cleared.
REQ-034 Set hs_access=1 for 30 cycles with pause_toggle=0 -> pause=1 the next cycle; dim_video stays 0 throughout.
REQ-035 Joy[7] and joy[8] rise on the same cycle -> a full coin pulse plus pause=1; the pulse length is unaffected by the pause.
REQ-036 Assert reset_n low 3 cycles into a coin pulse -> in0=8'hFF at once. After release with coin held, no pulse until coin is released and pressed again.

Source files
------------

// File: rtl/pengo_input_pkg.sv
// Shared constants for the Pengo input conditioner: joystick bit map,
// coin FSM states and production parameter defaults.
package pengo_input_pkg;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;
  localparam int JOY_PAUSE  = 8;
  localparam int JOY_BITS   = 9;

  localparam logic [15:0] DEBOUNCE_CYCLES_DEF   = 16'd24000;
  localparam logic [19:0] COIN_PULSE_CYCLES_DEF = 20'd480000;
  localparam logic [31:0] DIM_TIMEOUT_DEF       = 32'hE4E1C00;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_HOLD  = 2'd2
  } coin_state_t;

endpackage

// File: rtl/pengo_debounce.sv
// Single-bit debouncer: the stable state follows the raw input only after
// CYCLES consecutive samples that disagree with it.
module pengo_debounce #(
  parameter int unsigned CNT_W  = 15,
  parameter int unsigned CYCLES = 24000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= 1'b0;
      cnt_p0 <= '0;
    end else if (raw == stable) begin
      cnt_p0 <= '0;
    end else if (cnt_p0 == LAST) begin
      stable <= raw;
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

endmodule

// File: rtl/pengo_input_cond.sv
// Pengo input conditioner: debounces the merged joystick, builds the
// active-low IN0/IN1 ports, shapes the coin pulse and runs pause/dim control.
module pengo_input_cond
  import pengo_input_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter logic [19:0] COIN_PULSE_CYCLES = COIN_PULSE_CYCLES_DEF,
  parameter logic [31:0] DIM_TIMEOUT       = DIM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] joy,
  input  logic        hs_access,
  output logic [7:0]  in0,
  output logic [7:0]  in1,
  output logic        pause,
  output logic        dim_video
);

  localparam int unsigned DB_W    = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam int unsigned PULSE_W = $clog2(int'(COIN_PULSE_CYCLES) + 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(COIN_PULSE_CYCLES - 1'b1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v >= DIM_TIMEOUT) ? DIM_TIMEOUT : v + 32'd1;
  endfunction

  logic [JOY_BITS-1:0] db_p0;
  logic [JOY_BITS-1:0] db_p1;
  logic [JOY_BITS-1:0] act;
  logic                coin_rise;
  logic                pause_rise;
  logic                unused_joy_hi;

  coin_state_t         coin_state;
  logic [PULSE_W-1:0]  pulse_cnt;
  logic                coin_armed;
  logic                pause_toggle;
  logic [31:0]         timer;

  assign unused_joy_hi = ^joy[15:JOY_BITS];

  // Stage p0: per-button debounce
  for (genvar i = 0; i < JOY_BITS; i++) begin : g_db
    pengo_debounce #(
      .CNT_W (DB_W),
      .CYCLES(int'(DEBOUNCE_CYCLES))
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (joy[i]),
      .stable (db_p0[i])
    );
  end

  // Stage p1: edge detection, coin/pause control and registered outputs
  assign coin_rise  = db_p0[JOY_COIN]  & ~db_p1[JOY_COIN];
  assign pause_rise = db_p0[JOY_PAUSE] & ~db_p1[JOY_PAUSE];
  assign act        = db_p0 & {JOY_BITS{~pause_toggle}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_p1        <= '0;
      coin_state   <= COIN_IDLE;
      pulse_cnt    <= '0;
      coin_armed   <= 1'b0;
      pause_toggle <= 1'b0;
      timer        <= '0;
      in0          <= 8'hFF;
      in1          <= 8'hFF;
      pause        <= 1'b0;
      dim_video    <= 1'b0;
    end else begin
      db_p1 <= db_p0;

      // A coin held through reset must be seen released before it may credit.
      coin_armed <= coin_armed | ~joy[JOY_COIN];

      case (coin_state)
        COIN_IDLE: begin
          if (coin_rise && coin_armed && !pause_toggle) begin
            coin_state <= COIN_PULSE;
            pulse_cnt  <= '0;
          end
        end
        COIN_PULSE: begin
          if (pulse_cnt == PULSE_LAST) coin_state <= COIN_HOLD;
          else                         pulse_cnt  <= pulse_cnt + 1'b1;
        end
        COIN_HOLD: begin
          if (!db_p0[JOY_COIN]) coin_state <= COIN_IDLE;
        end
        default: coin_state <= COIN_IDLE;
      endcase

      pause_toggle <= pause_toggle ^ pause_rise;
      timer        <= pause_toggle ? sat_inc(timer) : 32'd0;
      pause        <= hs_access | pause_toggle;
      dim_video    <= (timer >= DIM_TIMEOUT);

      in0 <= ~{act[JOY_FIRE], 1'b0, coin_state == COIN_PULSE, 1'b0,
               act[JOY_RIGHT], act[JOY_LEFT], act[JOY_DOWN], act[JOY_UP]};
      in1 <= ~{act[JOY_START1], act[JOY_START2], act[JOY_START1], 1'b0,
               act[JOY_RIGHT], act[JOY_LEFT], act[JOY_DOWN], act[JOY_UP]};
    end
  end

endmodule

// File: tb/tb_pengo_input_cond.sv
// Self-checking bench for pengo_input_cond with short debounce/pulse/dim
// parameters and a cycle-level behavioural model of the input rules.
module tb_pengo_input_cond;

  localparam int N = 4;
  localparam int P = 8;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] joy;
  logic        hs_access;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic        pause;
  logic        dim_video;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pengo_input_cond #(
    .DEBOUNCE_CYCLES  (16'd4),
    .COIN_PULSE_CYCLES(20'd8),
    .DIM_TIMEOUT      (32'd16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .joy      (joy),
    .hs_access(hs_access),
    .in0      (in0),
    .in1      (in1),
    .pause    (pause),
    .dim_video(dim_video)
  );

  // Behavioural model: debounced button levels, pulse countdown, pause flag.
  logic [8:0] m_st;
  logic [8:0] m_prev;
  int         m_run [9];
  bit         m_pulse, m_hold, m_armed, m_ptog;
  int         m_rem, m_timer;
  logic [7:0] m_in0, m_in1;
  logic       m_pause, m_dim;

  task automatic model_reset();
    m_st = '0; m_prev = '0;
    for (int b = 0; b < 9; b++) m_run[b] = 0;
    m_pulse = 0; m_hold = 0; m_armed = 0; m_ptog = 0;
    m_rem = 0; m_timer = 0;
    m_in0 = 8'hFF; m_in1 = 8'hFF; m_pause = 0; m_dim = 0;
  endtask

  task automatic model_step();
    logic [8:0] act;
    logic       coin_edge, pause_edge;
    if (!reset_n) begin
      model_reset();
      return;
    end
    act        = m_ptog ? 9'd0 : m_st;
    coin_edge  = m_st[7] & ~m_prev[7];
    pause_edge = m_st[8] & ~m_prev[8];
    m_in0   = ~{act[4], 1'b0, m_pulse, 1'b0, act[0], act[1], act[2], act[3]};
    m_in1   = ~{act[5], act[6], act[5], 1'b0, act[0], act[1], act[2], act[3]};
    m_pause = hs_access | m_ptog;
    m_dim   = (m_timer >= T);
    m_timer = m_ptog ? ((m_timer < T) ? m_timer + 1 : T) : 0;
    if (m_pulse) begin
      if (m_rem == 1) begin m_pulse = 0; m_hold = 1; end
      else m_rem = m_rem - 1;
    end else if (m_hold) begin
      if (!m_st[7]) m_hold = 0;
    end else if (coin_edge && !m_ptog && m_armed) begin
      m_pulse = 1; m_rem = P;
    end
    m_armed = m_armed | ~joy[7];
    m_ptog  = m_ptog ^ pause_edge;
    m_prev  = m_st;
    for (int b = 0; b < 9; b++) begin
      if (joy[b] == m_st[b]) m_run[b] = 0;
      else if (m_run[b] + 1 == N) begin m_st[b] = joy[b]; m_run[b] = 0; end
      else m_run[b] = m_run[b] + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; joy = '0; hs_access = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++; if (in0 !== 8'hFF) begin errors++; $display("FAIL reset_in0: got %h expected ff", in0); end
    checks++; if (in1 !== 8'hFF) begin errors++; $display("FAIL reset_in1: got %h expected ff", in1); end
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b expected 0", pause); end
    checks++; if (dim_video !== 1'b0) begin errors++; $display("FAIL reset_dim: got %b expected 0", dim_video); end
    joy[3] = 1'b1;
    tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 4) begin
        checks++; if (in0[0] !== 1'b1) begin errors++; $display("FAIL held_thru_reset_early: got %b expected 1", in0[0]); end
      end
      if (i == 5) begin
        checks++; if (in0[0] !== 1'b0) begin errors++; $display("FAIL held_thru_reset_late: got %b expected 0", in0[0]); end
      end
    end
    joy = '0;
    repeat (6) tick();
  endtask

  task automatic test_debounce();
    int changed;
    joy[3] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 4) begin
        checks++; if ({in0[0], in1[0]} !== 2'b11) begin errors++; $display("FAIL up_latency_4: got %b expected 11", {in0[0], in1[0]}); end
      end
      if (i == 5) begin
        checks++; if ({in0[0], in1[0]} !== 2'b00) begin errors++; $display("FAIL up_latency_5: got %b expected 00", {in0[0], in1[0]}); end
      end
    end
    joy[3] = 1'b0;
    repeat (6) tick();
    checks++; if (in0 !== 8'hFF) begin errors++; $display("FAIL up_release: got %h expected ff", in0); end
    changed = 0;
    joy[0] = 1'b1;
    repeat (3) begin tick(); if (in0 !== 8'hFF) changed++; end
    joy[0] = 1'b0;
    repeat (8) begin tick(); if (in0 !== 8'hFF) changed++; end
    checks++; if (changed != 0) begin errors++; $display("FAIL glitch_filtered: got %0d changed cycles expected 0", changed); end
  endtask

  task automatic test_coin();
    int lows;
    lows = 0;
    joy[7] = 1'b1;
    repeat (40) begin tick(); if (in0[5] === 1'b0) lows++; end
    checks++; if (lows != P) begin errors++; $display("FAIL coin_pulse_len: got %0d expected %0d", lows, P); end
    checks++; if (in0 !== 8'hFF) begin errors++; $display("FAIL coin_after_pulse: got %h expected ff", in0); end
    joy[7] = 1'b0;
    repeat (10) tick();
    lows = 0;
    joy[7] = 1'b1;
    repeat (30) begin tick(); if (in0[5] === 1'b0) lows++; end
    checks++; if (lows != P) begin errors++; $display("FAIL coin_second_pulse: got %0d expected %0d", lows, P); end
    joy[7] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_pause();
    joy[3:0] = 4'hF;
    joy[8]   = 1'b1;
    repeat (10) tick();
    joy[8] = 1'b0;
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL pause_on: got %b expected 1", pause); end
    checks++; if ({in0, in1} !== 16'hFFFF) begin errors++; $display("FAIL pause_masked: got %h expected ffff", {in0, in1}); end
    checks++; if (dim_video !== 1'b0) begin errors++; $display("FAIL dim_early: got %b expected 0", dim_video); end
    repeat (20) tick();
    checks++; if (dim_video !== 1'b1) begin errors++; $display("FAIL dim_on: got %b expected 1", dim_video); end
    joy[8] = 1'b1;
    repeat (10) tick();
    joy[8] = 1'b0;
    checks++; if ({pause, dim_video} !== 2'b00) begin errors++; $display("FAIL pause_off: got %b expected 00", {pause, dim_video}); end
    checks++; if (in0[3:0] !== 4'h0) begin errors++; $display("FAIL unpause_dirs: got %h expected 0", in0[3:0]); end
    joy = '0;
    repeat (8) tick();
  endtask

  task automatic test_hs_access();
    int dims;
    dims = 0;
    hs_access = 1'b1;
    tick();
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL hs_pause_on: got %b expected 1", pause); end
    repeat (29) begin tick(); if (dim_video !== 1'b0) dims++; end
    checks++; if (dims != 0) begin errors++; $display("FAIL hs_no_dim: got %0d dim cycles expected 0", dims); end
    hs_access = 1'b0;
    tick();
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL hs_pause_off: got %b expected 0", pause); end
  endtask

  task automatic test_coin_pause_same();
    int lows;
    lows = 0;
    joy[7] = 1'b1; joy[8] = 1'b1;
    repeat (12) begin tick(); if (in0[5] === 1'b0) lows++; end
    joy[8] = 1'b0;
    repeat (28) begin tick(); if (in0[5] === 1'b0) lows++; end
    checks++; if (lows != P) begin errors++; $display("FAIL same_edge_pulse: got %0d expected %0d", lows, P); end
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL same_edge_pause: got %b expected 1", pause); end
    joy[7] = 1'b0;
    repeat (8) tick();
    joy[8] = 1'b1;
    repeat (10) tick();
    joy[8] = 1'b0;
    repeat (6) tick();
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL same_edge_unpause: got %b expected 0", pause); end
  endtask

  task automatic test_reset_mid_pulse();
    int lows;
    int waited;
    joy[7] = 1'b1;
    waited = 0;
    while (in0[5] !== 1'b0 && waited < 20) begin tick(); waited++; end
    checks++;
    if (in0[5] !== 1'b0) begin
      errors++; $display("FAIL midpulse_start: got %b expected 0 within 20 cycles", in0[5]);
    end
    repeat (2) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if ({in0, in1, pause, dim_video} !== 18'h3FFFC) begin errors++; $display("FAIL midpulse_async: got %h expected 3fffc", {in0, in1, pause, dim_video}); end
    @(negedge clk);
    repeat (2) tick();
    reset_n = 1'b1;
    lows = 0;
    repeat (30) begin tick(); if (in0[5] === 1'b0) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL midpulse_no_residual: got %0d expected 0", lows); end
    joy[7] = 1'b0;
    repeat (10) tick();
    lows = 0;
    joy[7] = 1'b1;
    repeat (30) begin tick(); if (in0[5] === 1'b0) lows++; end
    checks++; if (lows != P) begin errors++; $display("FAIL midpulse_repress: got %0d expected %0d", lows, P); end
    joy[7] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_random();
    logic [17:0] got_v, exp_v;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 9; b++) if ($urandom_range(7) == 0) joy[b] = ~joy[b];
      joy[15:9] = 7'($urandom);
      if ($urandom_range(31) == 0) hs_access = ~hs_access;
      tick();
      got_v = {in0, in1, pause, dim_video};
      exp_v = {m_in0, m_in1, m_pause, m_dim};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %h expected %h", i, got_v, exp_v);
      end
    end
    joy = '0; hs_access = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_coin();
    test_pause();
    test_hs_access();
    test_coin_pause_same();
    test_reset_mid_pulse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
